// File: rtl/bichito_motion_ctrl_if.sv
// Control/position bundle between the bichito motion sequencer and its
// neighbours (VGA timing, button pads, sprite renderer).
interface bichito_motion_ctrl_if;
    logic        frame_tick;
    logic        enable;
    logic        btn_left;
    logic        btn_right;
    logic        btn_up;
    logic [9:0]  curr_x;
    logic [31:0] curr_y;
    logic        jumping;
    logic        update_done;

    modport master (
        output frame_tick, enable, btn_left, btn_right, btn_up,
        input  curr_x, curr_y, jumping, update_done
    );

    modport slave (
        input  frame_tick, enable, btn_left, btn_right, btn_up,
        output curr_x, curr_y, jumping, update_done
    );
endinterface

// File: rtl/bichito_motion_ctrl.sv
// Per-frame motion sequencer for the bichito sprite: synchronised buttons,
// horizontal walk with edge clamps, and a ground/rise/fall jump FSM.
module bichito_motion_ctrl #(
    parameter logic [9:0] X_INIT      = 10'd315,
    parameter logic [9:0] Y_GROUND    = 10'd240,
    parameter logic [9:0] X_MIN       = 10'd0,
    parameter logic [9:0] X_MAX       = 10'd632,
    parameter logic [9:0] Y_MIN       = 10'd0,
    parameter logic [9:0] STEP_X      = 10'd2,
    parameter logic [9:0] STEP_Y      = 10'd3,
    parameter logic [7:0] JUMP_FRAMES = 8'd16
) (
    input logic                   clk,
    input logic                   rst,
    bichito_motion_ctrl_if.slave  bus
);
    typedef enum logic [1:0] {GROUND, RISE, FALL} state_t;

    state_t      state_q, state_d;
    logic [9:0]  x_q, x_d, y_q, y_d;
    logic [7:0]  air_q, air_d;
    logic        jump_req_q, jump_req_d;
    logic        jumping_q, done_q;
    logic [2:0]  sync1_q, sync2_q;      // {up, right, left}
    logic        up_prev_q;

    logic        upd, up_edge, left_s, right_s;
    logic [10:0] x_dec, x_inc, y_dec, y_inc;

    assign left_s  = sync2_q[0];
    assign right_s = sync2_q[1];
    assign up_edge = sync2_q[2] & ~up_prev_q;
    assign upd     = bus.frame_tick & bus.enable;

    // An edge coinciding with a tick survives; otherwise every tick drops the request.
    assign jump_req_d = up_edge | (jump_req_q & ~bus.frame_tick);

    // 11-bit arithmetic: bit 10 of a difference flags a borrow below zero.
    assign x_dec = {1'b0, x_q} - {1'b0, STEP_X};
    assign x_inc = {1'b0, x_q} + {1'b0, STEP_X};
    assign y_dec = {1'b0, y_q} - {1'b0, STEP_Y};
    assign y_inc = {1'b0, y_q} + {1'b0, STEP_Y};

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        air_d   = air_q;
        if (upd) begin
            if (left_s && !right_s)
                x_d = (x_dec[10] || (x_dec[9:0] < X_MIN)) ? X_MIN : x_dec[9:0];
            else if (right_s && !left_s)
                x_d = (x_inc > {1'b0, X_MAX}) ? X_MAX : x_inc[9:0];

            case (state_q)
                GROUND: begin
                    if (jump_req_q) begin
                        state_d = RISE;
                        y_d     = (y_dec[10] || (y_dec[9:0] < Y_MIN)) ? Y_MIN : y_dec[9:0];
                        air_d   = 8'd1;
                    end else begin
                        y_d = Y_GROUND;
                    end
                end
                RISE: begin
                    // The exit tick is a one-frame apex hold.
                    if (air_q == JUMP_FRAMES) begin
                        state_d = FALL;
                        air_d   = 8'd0;
                    end else begin
                        y_d   = (y_dec[10] || (y_dec[9:0] < Y_MIN)) ? Y_MIN : y_dec[9:0];
                        air_d = air_q + 8'd1;
                    end
                end
                FALL: begin
                    if (y_inc >= {1'b0, Y_GROUND}) begin
                        y_d     = Y_GROUND;
                        state_d = GROUND;
                    end else begin
                        y_d = y_inc[9:0];
                    end
                end
                default: begin
                    state_d = GROUND;
                    y_d     = Y_GROUND;
                    air_d   = 8'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= GROUND;
            x_q        <= X_INIT;
            y_q        <= Y_GROUND;
            air_q      <= 8'd0;
            jump_req_q <= 1'b0;
            jumping_q  <= 1'b0;
            done_q     <= 1'b0;
            sync1_q    <= 3'b000;
            sync2_q    <= 3'b000;
            up_prev_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            x_q        <= x_d;
            y_q        <= y_d;
            air_q      <= air_d;
            jump_req_q <= jump_req_d;
            jumping_q  <= (state_d != GROUND);
            done_q     <= upd;
            sync1_q    <= {bus.btn_up, bus.btn_right, bus.btn_left};
            sync2_q    <= sync1_q;
            up_prev_q  <= sync2_q[2];
        end
    end

    assign bus.curr_x      = x_q;
    assign bus.curr_y      = {22'b0, y_q};
    assign bus.jumping     = jumping_q;
    assign bus.update_done = done_q;
endmodule

// File: tb/tb_bichito_motion_ctrl.sv
// Directed bench for bichito_motion_ctrl: reset, walk clamps, jump profile,
// no double jump, enable gating, edge/tick collision and mid-jump reset.
module tb_bichito_motion_ctrl;
    logic clk = 1'b0;
    logic rst;
    int   n_pass = 0;
    int   n_chk  = 0;
    int   xe;

    bichito_motion_ctrl_if bus ();

    bichito_motion_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One-cycle frame tick; returns at the negedge after the processing edge.
    task automatic tick();
        @(negedge clk) bus.frame_tick = 1'b1;
        @(negedge clk) bus.frame_tick = 1'b0;
    endtask

    task automatic pulse_up();
        @(negedge clk) bus.btn_up = 1'b1;
        idle(4);
        bus.btn_up = 1'b0;
        idle(3);
    endtask

    function automatic int exp_y(input int k);
        if (k <= 16)      return 240 - 3 * k;
        else if (k == 17) return 192;
        else              return 192 + 3 * (k - 17);
    endfunction

    task automatic jump_profile(input string tag, input int rearm_at);
        pulse_up();
        for (int k = 1; k <= 33; k++) begin
            if (k == rearm_at) pulse_up();
            tick();
            chk({tag, "_y"}, bus.curr_y, exp_y(k));
            chk({tag, "_jmp"}, {31'b0, bus.jumping}, (k < 33) ? 32'd1 : 32'd0);
        end
    endtask

    initial begin
        rst = 1'b0;
        bus.frame_tick = 1'b0;
        bus.enable     = 1'b1;
        bus.btn_left   = 1'b0;
        bus.btn_right  = 1'b0;
        bus.btn_up     = 1'b0;
        idle(3);
        chk("rst_x", bus.curr_x, 315);
        chk("rst_y", bus.curr_y, 240);
        chk("rst_jmp", {31'b0, bus.jumping}, 0);
        chk("rst_done", {31'b0, bus.update_done}, 0);
        rst = 1'b1;

        // Buttons without a tick must not move anything.
        bus.btn_right = 1'b1;
        idle(6);
        chk("notick_x", bus.curr_x, 315);
        chk("notick_done", {31'b0, bus.update_done}, 0);

        // Walk right into the clamp.
        xe = 315;
        for (int i = 0; i < 200; i++) begin
            tick();
            xe = (xe > 630) ? 632 : xe + 2;
            chk("right_x", bus.curr_x, xe);
            if (i == 0) chk("tick_done", {31'b0, bus.update_done}, 1);
        end
        chk("right_clamp", bus.curr_x, 632);
        idle(1);
        chk("done_pulse", {31'b0, bus.update_done}, 0);

        bus.btn_left = 1'b1;
        idle(3);
        repeat (3) tick();
        chk("both_x", bus.curr_x, 632);

        // Walk left into the clamp.
        bus.btn_right = 1'b0;
        idle(3);
        for (int i = 0; i < 320; i++) begin
            tick();
            xe = (xe < 2) ? 0 : xe - 2;
            chk("left_x", bus.curr_x, xe);
        end
        chk("left_clamp", bus.curr_x, 0);
        bus.btn_left = 1'b0;
        idle(3);

        jump_profile("jump", 0);
        tick();
        chk("land_x", bus.curr_x, 0);

        // Second press during RISE is discarded.
        jump_profile("nodbl", 5);
        repeat (3) begin
            tick();
            chk("nodbl_y_after", bus.curr_y, 240);
            chk("nodbl_jmp_after", {31'b0, bus.jumping}, 0);
        end

        // Frozen: ticks ignored, jump request dropped.
        bus.enable = 1'b0;
        bus.btn_right = 1'b1;
        pulse_up();
        repeat (5) begin
            tick();
            chk("dis_x", bus.curr_x, 0);
            chk("dis_y", bus.curr_y, 240);
            chk("dis_done", {31'b0, bus.update_done}, 0);
        end
        bus.enable = 1'b1;
        bus.btn_right = 1'b0;
        idle(3);
        repeat (2) begin
            tick();
            chk("reen_y", bus.curr_y, 240);
            chk("reen_jmp", {31'b0, bus.jumping}, 0);
            chk("reen_done", {31'b0, bus.update_done}, 1);
        end

        // Synchronised up-edge lands on the same edge as a tick.
        @(negedge clk) bus.btn_up = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk) bus.frame_tick = 1'b1;
        @(negedge clk) bus.frame_tick = 1'b0;
        chk("coll_y0", bus.curr_y, 240);
        chk("coll_jmp0", {31'b0, bus.jumping}, 0);
        bus.btn_up = 1'b0;
        tick();
        chk("coll_y1", bus.curr_y, 237);
        chk("coll_jmp1", {31'b0, bus.jumping}, 1);

        // Reset mid-jump.
        bus.btn_right = 1'b1;
        idle(3);
        repeat (3) tick();
        chk("pre_rst_y", bus.curr_y, 228);
        chk("pre_rst_x", bus.curr_x, 6);
        @(negedge clk) rst = 1'b0;
        idle(3);
        chk("mid_rst_x", bus.curr_x, 315);
        chk("mid_rst_y", bus.curr_y, 240);
        chk("mid_rst_jmp", {31'b0, bus.jumping}, 0);
        chk("mid_rst_done", {31'b0, bus.update_done}, 0);
        rst = 1'b1;
        idle(4);
        chk("post_rst_x", bus.curr_x, 315);
        bus.btn_right = 1'b0;
        idle(3);
        tick();
        chk("post_rst_y", bus.curr_y, 240);
        chk("post_rst_jmp", {31'b0, bus.jumping}, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
